mask_acc_64b: RTL and testbench

Burst accumulator directly downstream of `dec_64b`. It consumes the decoder's one-hot 64-bit words and ORs each burst of valid beats into a 64-bit set mask, keeping a running population count. At end of burst it emits the mask, the count, a duplicate-hit flag and a malformed-input flag as a one-cycle result.

---
 rtl/mask_acc_64b.sv | 140 ++++++++++++++
 tb/tb_mask_acc_64b.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mask_acc_64b.sv
// ============================================================================
// Module   : mask_acc_64b
// Purpose  : ORs each burst of one-hot beats into a 64-bit set mask and
//            reports mask, population count, duplicate and malformed flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mask_acc_64b #(
    parameter int OUT_REG = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] in_data_i,
    input  logic        in_valid_i,
    output logic [63:0] out_mask_o,
    output logic [6:0]  out_count_o,
    output logic        out_dup_o,
    output logic        out_err_o,
    output logic        out_valid_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t      r_state_q,    w_state_d;
    logic [63:0] r_acc_mask_q, w_acc_mask_d;
    logic [6:0]  r_acc_cnt_q,  w_acc_cnt_d;
    logic        r_acc_dup_q,  w_acc_dup_d;
    logic        r_acc_err_q,  w_acc_err_d;

    logic w_one_hot;
    logic w_hit;
    logic w_end;

    // The accumulator is all-zero whenever the FSM is idle, so the first beat
    // of a burst is naturally classified against an empty mask.
    assign w_one_hot = (in_data_i != 64'd0) && ((in_data_i & (in_data_i - 64'd1)) == 64'd0);
    assign w_hit     = |(in_data_i & r_acc_mask_q);
    assign w_end     = (r_state_q == S_ACC) && !in_valid_i;

    always_comb begin
        w_state_d    = r_state_q;
        w_acc_mask_d = r_acc_mask_q;
        w_acc_cnt_d  = r_acc_cnt_q;
        w_acc_dup_d  = r_acc_dup_q;
        w_acc_err_d  = r_acc_err_q;
        if (in_valid_i) begin
            w_state_d = S_ACC;
            if (!w_one_hot) begin
                w_acc_err_d = 1'b1;
            end else if (w_hit) begin
                w_acc_dup_d = 1'b1;
            end else begin
                w_acc_mask_d = r_acc_mask_q | in_data_i;
                w_acc_cnt_d  = r_acc_cnt_q + 7'd1;
            end
        end else if (r_state_q == S_ACC) begin
            w_state_d    = S_IDLE;
            w_acc_mask_d = 64'd0;
            w_acc_cnt_d  = 7'd0;
            w_acc_dup_d  = 1'b0;
            w_acc_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q    <= S_IDLE;
            r_acc_mask_q <= 64'd0;
            r_acc_cnt_q  <= 7'd0;
            r_acc_dup_q  <= 1'b0;
            r_acc_err_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_acc_mask_q <= w_acc_mask_d;
            r_acc_cnt_q  <= w_acc_cnt_d;
            r_acc_dup_q  <= w_acc_dup_d;
            r_acc_err_q  <= w_acc_err_d;
        end
    end

    generate
        if (OUT_REG == 0) begin : g_out_comb
            assign out_valid_o = w_end && !rst_i;
            assign out_mask_o  = r_acc_mask_q;
            assign out_count_o = r_acc_cnt_q;
            assign out_dup_o   = r_acc_dup_q;
            assign out_err_o   = r_acc_err_q;
        end else begin : g_out_reg
            logic        r_out_valid_q, w_out_valid_d;
            logic [63:0] r_out_mask_q,  w_out_mask_d;
            logic [6:0]  r_out_count_q, w_out_count_d;
            logic        r_out_dup_q,   w_out_dup_d;
            logic        r_out_err_q,   w_out_err_d;

            // Data is captured only at a burst end and otherwise held.
            always_comb begin
                w_out_valid_d = w_end;
                w_out_mask_d  = r_out_mask_q;
                w_out_count_d = r_out_count_q;
                w_out_dup_d   = r_out_dup_q;
                w_out_err_d   = r_out_err_q;
                if (w_end) begin
                    w_out_mask_d  = r_acc_mask_q;
                    w_out_count_d = r_acc_cnt_q;
                    w_out_dup_d   = r_acc_dup_q;
                    w_out_err_d   = r_acc_err_q;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_out_valid_q <= 1'b0;
                    r_out_mask_q  <= 64'd0;
                    r_out_count_q <= 7'd0;
                    r_out_dup_q   <= 1'b0;
                    r_out_err_q   <= 1'b0;
                end else begin
                    r_out_valid_q <= w_out_valid_d;
                    r_out_mask_q  <= w_out_mask_d;
                    r_out_count_q <= w_out_count_d;
                    r_out_dup_q   <= w_out_dup_d;
                    r_out_err_q   <= w_out_err_d;
                end
            end

            assign out_valid_o = r_out_valid_q;
            assign out_mask_o  = r_out_mask_q;
            assign out_count_o = r_out_count_q;
            assign out_dup_o   = r_out_dup_q;
            assign out_err_o   = r_out_err_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mask_acc_64b.sv
// ============================================================================
// Module   : tb_mask_acc_64b
// Purpose  : Checks mask_acc_64b (both result timings) against a burst model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mask_acc_64b;

    logic        clk;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;

    logic [63:0] c_mask, r_mask;
    logic [6:0]  c_count, r_count;
    logic        c_dup, r_dup, c_err, r_err, c_valid, r_valid;

    int n_checks = 0;
    int n_errors = 0;

    mask_acc_64b #(.OUT_REG(0)) u_dut_comb (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .out_mask_o  (c_mask),
        .out_count_o (c_count),
        .out_dup_o   (c_dup),
        .out_err_o   (c_err),
        .out_valid_o (c_valid)
    );

    mask_acc_64b #(.OUT_REG(1)) u_dut_reg (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .out_mask_o  (r_mask),
        .out_count_o (r_count),
        .out_dup_o   (r_dup),
        .out_err_o   (r_err),
        .out_valid_o (r_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the beats of the open burst are kept as a list and the
    // result is derived from them only when the burst closes.
    logic [63:0] m_beats[$];
    logic        m_active   = 1'b0;
    logic        m_pend     = 1'b0;
    logic [63:0] m_h_mask   = 64'd0;
    logic [6:0]  m_h_count  = 7'd0;
    logic        m_h_dup    = 1'b0;
    logic        m_h_err    = 1'b0;
    logic        mon_en     = 1'b0;

    function automatic void model_result(output logic [63:0] m, output logic [6:0] c,
                                         output logic d, output logic e);
        m = 64'd0;
        d = 1'b0;
        e = 1'b0;
        foreach (m_beats[i]) begin
            if ($countones(m_beats[i]) != 1) e = 1'b1;
            else if ((m & m_beats[i]) != 64'd0) d = 1'b1;
            else m = m | m_beats[i];
        end
        c = 7'($countones(m));
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            logic [63:0] em;
            logic [6:0]  ec;
            logic        ed, ee, ev;
            model_result(em, ec, ed, ee);
            ev = m_active && !in_valid && !rst;

            check("comb_valid", 64'(c_valid), 64'(ev));
            if (ev) begin
                check("comb_mask",  c_mask,        em);
                check("comb_count", 64'(c_count), 64'(ec));
                check("comb_dup",   64'(c_dup),   64'(ed));
                check("comb_err",   64'(c_err),   64'(ee));
            end
            check("reg_valid", 64'(r_valid), 64'(m_pend));
            check("reg_mask",  r_mask,       m_h_mask);
            check("reg_count", 64'(r_count), 64'(m_h_count));
            check("reg_dup",   64'(r_dup),   64'(m_h_dup));
            check("reg_err",   64'(r_err),   64'(m_h_err));

            // Predict the effect of the coming rising edge.
            if (rst) begin
                m_beats.delete();
                m_active  = 1'b0;
                m_pend    = 1'b0;
                m_h_mask  = 64'd0;
                m_h_count = 7'd0;
                m_h_dup   = 1'b0;
                m_h_err   = 1'b0;
            end else begin
                m_pend = ev;
                if (ev) begin
                    m_h_mask  = em;
                    m_h_count = ec;
                    m_h_dup   = ed;
                    m_h_err   = ee;
                end
                if (in_valid) begin
                    m_beats.push_back(in_data);
                    m_active = 1'b1;
                end else if (m_active) begin
                    m_beats.delete();
                    m_active = 1'b0;
                end
            end
        end
    end

    task automatic beat(input logic [63:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_held(input string tag, input logic [63:0] m, input logic [6:0] c,
                               input logic d, input logic e);
        check({tag, "_mask"},  r_mask,       m);
        check({tag, "_count"}, 64'(r_count), 64'(c));
        check({tag, "_dup"},   64'(r_dup),   64'(d));
        check({tag, "_err"},   64'(r_err),   64'(e));
    endtask

    function automatic logic [63:0] rand_word();
        int unsigned sel;
        int unsigned a, b;
        sel = $urandom_range(0, 9);
        a   = $urandom_range(0, 63);
        b   = (a + $urandom_range(1, 63)) % 64;
        if (sel == 0) return 64'd0;
        if (sel == 1) return (64'd1 << a) | (64'd1 << b);
        return 64'd1 << $urandom_range(0, 15);
    endfunction

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(2);
        expect_held("reset", 64'd0, 7'd0, 1'b0, 1'b0);

        for (int i = 0; i < 64; i++) beat(64'd1 << i);
        idle(3);
        expect_held("full", 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b0, 1'b0);

        beat(64'd1 << 3);
        beat(64'd1 << 3);
        beat(64'd1 << 63);
        idle(3);
        expect_held("dup", 64'h8000_0000_0000_0008, 7'd2, 1'b1, 1'b0);

        beat(64'd0);
        beat(64'h3);
        beat(64'd1 << 5);
        idle(3);
        expect_held("err", 64'h20, 7'd1, 1'b0, 1'b1);

        beat(64'd1);
        idle(1);
        beat(64'd2);
        expect_held("b2b_hold", 64'h1, 7'd1, 1'b0, 1'b0);
        idle(3);
        expect_held("b2b_second", 64'h2, 7'd1, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) beat(64'd1 << i);
        rst = 1'b1;
        beat(64'd1 << 10);
        rst = 1'b0;
        for (int i = 10; i < 13; i++) beat(64'd1 << i);
        idle(3);
        expect_held("abort", 64'h1C00, 7'd3, 1'b0, 1'b0);

        for (int i = 0; i < 70; i++) beat(64'd1 << (i % 64));
        idle(3);
        expect_held("long", 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int len;
            len = (n % 10 == 9) ? int'($urandom_range(66, 80)) : int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) beat(rand_word());
            idle(int'($urandom_range(1, 3)));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
